// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port synchronous RAM
// between a data port (p0) and an instruction-fetch port (p1). One
// transaction is in flight at a time: IDLE -> ACCESS -> RESP -> IDLE.

module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 16,
    localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [AW-1:0]         p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ready,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [AW-1:0]         p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ready,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,

    output logic [AW-1:0]         mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  p0_rvalid_q, p0_rvalid_d;
    logic                  p1_rvalid_q, p1_rvalid_d;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
    logic                  winner;

    // A lone requester always wins; on contention the priority pointer decides.
    always_comb begin
        winner = prio_q;
        if (p0_req && !p1_req) begin
            winner = 1'b0;
        end else if (p1_req && !p0_req) begin
            winner = 1'b1;
        end
    end

    // Ready is gated by reset so nothing looks accepted while reset is held.
    assign p0_ready = rst_n && (state_q == IDLE) && p0_req && !winner;
    assign p1_ready = rst_n && (state_q == IDLE) && p1_req &&  winner;

    // Next-state and registered-output logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_en_d = mem_rd_en_q;
        mem_wr_en_d = mem_wr_en_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        case (state_q)
            IDLE: begin
                if (p0_ready || p1_ready) begin
                    owner_d     = winner;
                    we_d        = winner ? p1_we : p0_we;
                    mem_addr_d  = winner ? p1_addr : p0_addr;
                    mem_wdata_d = winner ? p1_wdata : p0_wdata;
                    mem_rd_en_d = winner ? !p1_we : !p0_we;
                    mem_wr_en_d = winner ? p1_we : p0_we;
                    prio_d      = !winner;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                mem_rd_en_d = 1'b0;
                mem_wr_en_d = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                if (owner_q) begin
                    p1_rvalid_d = 1'b1;
                    p1_rdata_d  = we_q ? '0 : mem_rdata;
                end else begin
                    p0_rvalid_d = 1'b1;
                    p0_rdata_d  = we_q ? '0 : mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter and its memory.

module tb_mem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en, mem_wr_en;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;
    logic envInit = 1'b1;

    function automatic logic [DW-1:0] initWord(input int i);
        return (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
    endfunction

    // Behavioural stand-in for the synchronous single-port ReadWriteMemory.
    logic [DW-1:0] envMem [DEPTH];
    always @(posedge clk) begin
        if (envInit) begin
            for (int i = 0; i < DEPTH; i++) envMem[i] <= initWord(i);
        end else begin
            if (mem_wr_en) envMem[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= envMem[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: time of last acceptance, its contents, a shadow memory.
    int            cyc = 0;
    int            lastAcc = -100;
    bit            accPort, accWe, prio;
    logic [AW-1:0] accAddr, mAddr;
    logic [DW-1:0] accWdata, accData, mWdata;
    logic [DW-1:0] expRdata [2];
    logic [DW-1:0] shadow [DEPTH];

    function automatic bit modelReady(input int port);
        bit busy, win;
        busy = (cyc - lastAcc) < 2;
        if (p0_req && !p1_req)      win = 1'b0;
        else if (p1_req && !p0_req) win = 1'b1;
        else                        win = prio;
        return (rst_n === 1'b1) && !busy && ((port == 0) ? p0_req : p1_req) && (win == port[0]);
    endfunction

    always @(posedge clk) begin : modelUpdate
        bit r0, r1;
        r0 = modelReady(0);
        r1 = modelReady(1);
        cyc++;
        if (envInit) begin
            for (int i = 0; i < DEPTH; i++) shadow[i] = initWord(i);
        end
        if (rst_n !== 1'b1) begin
            lastAcc     = -100;
            prio        = 1'b0;
            mAddr       = '0;
            mWdata      = '0;
            expRdata[0] = '0;
            expRdata[1] = '0;
        end else begin
            if (lastAcc == cyc - 2) expRdata[accPort] = accData;
            if (r0 || r1) begin
                accPort  = r1;
                accWe    = r1 ? p1_we : p0_we;
                accAddr  = r1 ? p1_addr : p0_addr;
                accWdata = r1 ? p1_wdata : p0_wdata;
                lastAcc  = cyc;
                prio     = !accPort;
                mAddr    = accAddr;
                mWdata   = accWdata;
                if (accWe) begin
                    shadow[accAddr] = accWdata;
                    accData = '0;
                end else begin
                    accData = shadow[accAddr];
                end
            end
        end
    end

    // Single compare process: every output against the model, once per cycle.
    bit sawRdy0 = 1'b0, sawRdy1 = 1'b0;
    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("p0_ready",  32'(p0_ready),  32'(modelReady(0)));
            checkOutput("p1_ready",  32'(p1_ready),  32'(modelReady(1)));
            checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(lastAcc == cyc && !accWe));
            checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(lastAcc == cyc && accWe));
            checkOutput("mem_addr",  32'(mem_addr),  32'(mAddr));
            checkOutput("mem_wdata", mem_wdata, mWdata);
            checkOutput("p0_rvalid", 32'(p0_rvalid), 32'(lastAcc == cyc - 2 && accPort == 1'b0));
            checkOutput("p1_rvalid", 32'(p1_rvalid), 32'(lastAcc == cyc - 2 && accPort == 1'b1));
            checkOutput("p0_rdata",  p0_rdata, expRdata[0]);
            checkOutput("p1_rdata",  p1_rdata, expRdata[1]);
        end
        sawRdy0 = p0_req && p0_ready;
        sawRdy1 = p1_req && p1_ready;
    end

    // Grant log built from handshakes seen just before each edge.
    int grantPort[$];
    int grantCyc[$];
    int edgeCnt = 0;
    bit acc0 = 1'b0, acc1 = 1'b0;
    always @(posedge clk) begin
        edgeCnt++;
        acc0 = (rst_n === 1'b1) && sawRdy0;
        acc1 = (rst_n === 1'b1) && sawRdy1;
        if (acc0) begin grantPort.push_back(0); grantCyc.push_back(edgeCnt); end
        if (acc1) begin grantPort.push_back(1); grantCyc.push_back(edgeCnt); end
    end

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = data;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = data;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Issue one transaction on a port; report response data and latency in cycles.
    task automatic doTxn(input int port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, output logic [DW-1:0] rdata, output int lat);
        bit ok = 1'b0;
        rdata = '0;
        lat = -1;
        applyStimulus(port, 1'b1, we, addr, data);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_ready : p1_ready) begin ok = 1'b1; break; end
        end
        nextCycle();
        applyStimulus(port, 1'b0, we, addr, data);
        if (!ok) begin
            checkOutput("grant timeout", 32'd0, 32'd1);
            return;
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if ((port == 0) ? p0_rvalid : p1_rvalid) begin
                rdata = (port == 0) ? p0_rdata : p1_rdata;
                lat = j;
                break;
            end
            @(posedge clk);
        end
        if (lat < 0) checkOutput("rvalid timeout", 32'd0, 32'd1);
        nextCycle();
    endtask

    task automatic waitGrants(input int base, input int n);
        for (int i = 0; i < 40; i++) begin
            if (grantPort.size() >= base + n) return;
            nextCycle();
        end
        checkOutput("waitGrants timeout", 32'(grantPort.size()), 32'(base + n));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        int lat, base;
        bit seen;
        rst_n = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 4'd0, 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 4'd0, 32'd0);

        // Reset held two cycles with both ports requesting.
        @(posedge clk); #2; envInit = 1'b0;
        @(negedge clk);
        checkOutput("reset p0_ready", 32'(p0_ready), 32'd0);
        checkOutput("reset p1_ready", 32'(p1_ready), 32'd0);
        checkOutput("reset mem_rd_en", 32'(mem_rd_en), 32'd0);
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release p0_ready", 32'(p0_ready), 32'd1);
        checkOutput("release p1_ready", 32'(p1_ready), 32'd0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 4'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 4'd0, 32'd0);
        repeat (4) nextCycle();

        // Single write then read on port 0.
        doTxn(0, 1'b1, 4'd5, 32'hDEADBEEF, rd, lat);
        checkOutput("write latency", 32'(lat), 32'd2);
        checkOutput("write rdata", rd, 32'd0);
        doTxn(0, 1'b0, 4'd5, 32'd0, rd, lat);
        checkOutput("read latency", 32'(lat), 32'd2);
        checkOutput("read rdata", rd, 32'hDEADBEEF);

        // Contention: last grant was port 0, so port 1 leads, then alternation.
        base = grantPort.size();
        applyStimulus(0, 1'b1, 1'b0, 4'd1, 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 4'd2, 32'd0);
        waitGrants(base, 4);
        applyStimulus(0, 1'b0, 1'b0, 4'd1, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 4'd2, 32'd0);
        if (grantPort.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("contention order", 32'(grantPort[base + k]), 32'(k % 2 == 0 ? 1 : 0));
                if (k > 0) checkOutput("contention spacing",
                                       32'(grantCyc[base + k] - grantCyc[base + k - 1]), 32'd3);
            end
        end
        repeat (4) nextCycle();

        // Lone requester on port 1.
        base = grantPort.size();
        applyStimulus(1, 1'b1, 1'b0, 4'd9, 32'd0);
        waitGrants(base, 4);
        applyStimulus(1, 1'b0, 1'b0, 4'd9, 32'd0);
        if (grantPort.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("lone port", 32'(grantPort[base + k]), 32'd1);
                if (k > 0) checkOutput("lone spacing",
                                       32'(grantCyc[base + k] - grantCyc[base + k - 1]), 32'd3);
            end
        end
        repeat (4) nextCycle();

        // Cross-port coherence on address 15.
        base = grantPort.size();
        seen = 1'b0;
        rd = '0;
        applyStimulus(0, 1'b1, 1'b1, 4'd15, 32'h12345678);
        applyStimulus(1, 1'b1, 1'b0, 4'd15, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p1_rvalid) begin rd = p1_rdata; seen = 1'b1; end
            nextCycle();
            if (acc0) p0_req = 1'b0;
            if (acc1) p1_req = 1'b0;
            if (seen) break;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        checkOutput("coherence seen", 32'(seen), 32'd1);
        checkOutput("coherence rdata", rd, 32'h12345678);
        if (grantPort.size() >= base + 2) begin
            checkOutput("coherence first", 32'(grantPort[base]), 32'd0);
            checkOutput("coherence second", 32'(grantPort[base + 1]), 32'd1);
        end
        repeat (3) nextCycle();

        // Reset sampled at the end of RESP of a port-0 read.
        seen = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 4'd3, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (p0_ready) begin seen = 1'b1; break; end
        end
        checkOutput("midreset grant", 32'(seen), 32'd1);
        nextCycle();
        p0_req = 1'b0;
        nextCycle();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("midreset p0_rvalid", 32'(p0_rvalid), 32'd0);
        end
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 4'd4, 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 4'd6, 32'd0);
        @(negedge clk);
        checkOutput("post-reset p0_ready", 32'(p0_ready), 32'd1);
        checkOutput("post-reset p1_ready", 32'(p1_ready), 32'd0);
        nextCycle();
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (4) nextCycle();

        // Randomized traffic with holds, cancellations and mixed read/write.
        for (int c = 0; c < 400; c++) begin
            if (p0_req && !acc0) begin
                if ($urandom_range(9) == 0) p0_req = 1'b0;
            end else begin
                applyStimulus(0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                              4'($urandom_range(15)), $urandom);
            end
            if (p1_req && !acc1) begin
                if ($urandom_range(9) == 0) p1_req = 1'b0;
            end else begin
                applyStimulus(1, 1'($urandom_range(1)), 1'($urandom_range(1)),
                              4'($urandom_range(15)), $urandom);
            end
            nextCycle();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (5) nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
